// File: rtl/hrg_io_bridge.sv
// Z80-side I/O front end for the HRG: register window decode, port0/port1 forwarding to the display,
// auto-incrementing pixel RAM access and a hardware fill engine.
module hrg_io_bridge #(
  parameter int unsigned MEM_AW   = 14,
  parameter int unsigned FILL_LEN = 16384
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2:0]        i_io_addr,
  input  logic              i_io_wr,
  input  logic              i_io_rd,
  input  logic [7:0]        i_io_wdata,
  output logic [7:0]        o_io_rdata,
  output logic              o_io_rdata_valid,
  output logic [7:0]        o_hrg_port0,
  output logic              o_hrg_port0_valid,
  output logic [7:0]        o_hrg_port1,
  output logic              o_hrg_port1_valid,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_FILL} state_t;

  localparam logic [MEM_AW-1:0] FILL_LAST = MEM_AW'(FILL_LEN - 1);
  localparam logic [MEM_AW-1:0] PTR_ONE   = MEM_AW'(1);

  state_t            state_q;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        rdata_q, port0_q, port1_q, mem_wdata_q;
  logic              rdata_valid_q, port0_valid_q, port1_valid_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              busy, wr_en, rd_en;

  always_comb begin
    busy  = (state_q != S_IDLE);
    wr_en = i_io_wr;
    // A simultaneous write wins; the read strobe is discarded.
    rd_en = i_io_rd & ~i_io_wr;
    ptr_d = ptr_q;
    if (wr_en && !busy) begin
      case (i_io_addr)
        3'd2:    ptr_d[7:0]        = i_io_wdata;
        3'd3:    ptr_d[MEM_AW-1:8] = i_io_wdata[MEM_AW-9:0];
        3'd4:    ptr_d             = ptr_q + PTR_ONE;
        default: ptr_d             = ptr_q;
      endcase
    end else if (rd_en && !busy && i_io_addr == 3'd5) begin
      ptr_d = ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      port0_q       <= '0;
      port0_valid_q <= 1'b0;
      port1_q       <= '0;
      port1_valid_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      rdata_valid_q <= 1'b0;
      port0_valid_q <= 1'b0;
      port1_valid_q <= 1'b0;
      mem_we_q      <= 1'b0;

      if (wr_en && i_io_addr == 3'd0) begin
        port0_q       <= i_io_wdata;
        port0_valid_q <= 1'b1;
      end
      if (wr_en && i_io_addr == 3'd1) begin
        port1_q       <= i_io_wdata;
        port1_valid_q <= 1'b1;
      end
      // Offsets 0/1 are write-only but still answer reads, even while busy.
      if (rd_en && i_io_addr <= 3'd1) begin
        rdata_q       <= '0;
        rdata_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            case (i_io_addr)
              3'd4: begin
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= i_io_wdata;
                mem_we_q    <= 1'b1;
              end
              3'd6: begin
                state_q     <= S_FILL;
                mem_addr_q  <= '0;
                mem_wdata_q <= i_io_wdata;
                mem_we_q    <= 1'b1;
              end
              default: ;
            endcase
          end else if (rd_en) begin
            case (i_io_addr)
              3'd2: begin
                rdata_q       <= ptr_q[7:0];
                rdata_valid_q <= 1'b1;
              end
              3'd3: begin
                rdata_q       <= 8'(ptr_q >> 8);
                rdata_valid_q <= 1'b1;
              end
              3'd5: begin
                state_q    <= S_RD1;
                mem_addr_q <= ptr_q;
              end
              3'd7: begin
                rdata_q       <= {7'b0, busy};
                rdata_valid_q <= 1'b1;
              end
              3'd4, 3'd6: begin
                rdata_q       <= '0;
                rdata_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RD1: state_q <= S_RD2;
        S_RD2: begin
          rdata_q       <= i_mem_rdata;
          rdata_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        S_FILL: begin
          // Address register doubles as the fill counter.
          if (mem_addr_q == FILL_LAST) begin
            state_q <= S_IDLE;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= mem_addr_q + PTR_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_io_rdata        = rdata_q;
  assign o_io_rdata_valid  = rdata_valid_q;
  assign o_hrg_port0       = port0_q;
  assign o_hrg_port0_valid = port0_valid_q;
  assign o_hrg_port1       = port1_q;
  assign o_hrg_port1_valid = port1_valid_q;
  assign o_mem_addr        = mem_addr_q;
  assign o_mem_wdata       = mem_wdata_q;
  assign o_mem_we          = mem_we_q;
  assign o_busy            = busy;

endmodule

// File: tb/tb_hrg_io_bridge.sv
// Directed bench for hrg_io_bridge with a behavioural pixel RAM (one-cycle read latency).
module tb_hrg_io_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  io_addr;
  logic        io_wr, io_rd;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_rdata_valid;
  logic [7:0]  port0, port1;
  logic        port0_valid, port1_valid;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, busy;

  logic [7:0]  ram [0:16383];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hrg_io_bridge #(.MEM_AW(14), .FILL_LEN(16384)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_io_addr(io_addr), .i_io_wr(io_wr), .i_io_rd(io_rd),
    .i_io_wdata(io_wdata), .o_io_rdata(io_rdata), .o_io_rdata_valid(io_rdata_valid),
    .o_hrg_port0(port0), .o_hrg_port0_valid(port0_valid),
    .o_hrg_port1(port1), .o_hrg_port1_valid(port1_valid),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1; io_rd = 1'b0;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1; io_wr = 1'b0;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_rdata;
    v = io_rdata_valid;
  endtask

  initial begin
    logic [7:0] d;
    logic       v;
    int         bad, vcnt, wcnt;

    rst_n = 1'b0; io_addr = '0; io_wr = 1'b0; io_rd = 1'b0; io_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_outputs", {port0, port1, io_rdata, mem_wdata},  32'h0);
    check("rst_strobes", {port0_valid, port1_valid, io_rdata_valid, mem_we, busy}, 32'h0);
    check("rst_addr", {18'h0, mem_addr}, 32'h0);

    // Forwarding
    wr_reg(3'd0, 8'hA3);
    check("p0_data", {24'h0, port0}, 32'hA3);
    check("p0_valid", {31'h0, port0_valid}, 32'h1);
    check("p1_quiet", {31'h0, port1_valid}, 32'h0);
    @(negedge clk);
    check("p0_valid_drop", {31'h0, port0_valid}, 32'h0);
    wr_reg(3'd1, 8'h5F);
    check("p1_data", {24'h0, port1}, 32'h5F);
    check("p1_valid", {31'h0, port1_valid}, 32'h1);
    @(negedge clk);
    check("p1_valid_drop", {31'h0, port1_valid}, 32'h0);

    // Back-to-back writes across the pointer wrap
    wr_reg(3'd2, 8'hFE);
    wr_reg(3'd3, 8'h3F);
    @(negedge clk);
    io_addr = 3'd4; io_wdata = 8'h11; io_wr = 1'b1;
    @(negedge clk);
    check("w1", {mem_we, 9'h0, mem_addr, mem_wdata}, {1'b1, 9'h0, 14'h3FFE, 8'h11});
    io_wdata = 8'h22;
    @(negedge clk);
    check("w2", {mem_we, 9'h0, mem_addr, mem_wdata}, {1'b1, 9'h0, 14'h3FFF, 8'h22});
    io_wdata = 8'h33;
    @(negedge clk);
    io_wr = 1'b0;
    check("w3", {mem_we, 9'h0, mem_addr, mem_wdata}, {1'b1, 9'h0, 14'h0000, 8'h33});
    @(negedge clk);
    check("w_end", {31'h0, mem_we}, 32'h0);
    check("ram_wrap", {8'h0, ram[14'h3FFE], ram[14'h3FFF], ram[14'h0000]}, 32'h00112233);
    rd_reg(3'd2, d, v);
    check("ptr_lo_wrap", {23'h0, v, d}, 32'h101);
    rd_reg(3'd3, d, v);
    check("ptr_hi_wrap", {23'h0, v, d}, 32'h100);

    // Memory read latency
    wr_reg(3'd2, 8'h23);
    wr_reg(3'd3, 8'h01);
    wr_reg(3'd4, 8'h9C);
    wr_reg(3'd2, 8'h23);
    @(negedge clk);
    io_addr = 3'd5; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    check("rd_t1", {busy, io_rdata_valid, mem_we, 15'h0, mem_addr}, {3'b100, 15'h0, 14'h0123});
    @(negedge clk);
    check("rd_t2", {30'h0, busy, io_rdata_valid}, 32'h2);
    @(negedge clk);
    check("rd_t3", {22'h0, busy, io_rdata_valid, io_rdata}, {22'h0, 2'b01, 8'h9C});
    @(negedge clk);
    check("rd_t4", {31'h0, io_rdata_valid}, 32'h0);
    rd_reg(3'd2, d, v);
    check("ptr_lo_rd", {23'h0, v, d}, 32'h124);
    rd_reg(3'd3, d, v);
    check("ptr_hi_rd", {23'h0, v, d}, 32'h101);

    // Full fill with accesses during the fill
    wr_reg(3'd2, 8'h55);
    wr_reg(3'd3, 8'h00);
    @(negedge clk);
    io_addr = 3'd6; io_wdata = 8'h00; io_wr = 1'b1;
    bad = 0; vcnt = 0;
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      io_wr = 1'b0; io_rd = 1'b0;
      if (!(mem_we === 1'b1 && mem_addr === 14'(i) && mem_wdata === 8'h00 && busy === 1'b1)) bad++;
      if (io_rdata_valid !== 1'b0) vcnt++;
      if (i == 71) check("fill_fwd", {23'h0, port0_valid, port0}, 32'h15A);
      case (i)
        50: begin io_addr = 3'd7; io_rd = 1'b1; end
        60: begin io_addr = 3'd4; io_wdata = 8'hAA; io_wr = 1'b1; end
        70: begin io_addr = 3'd0; io_wdata = 8'h5A; io_wr = 1'b1; end
        80: begin io_addr = 3'd2; io_wdata = 8'h99; io_wr = 1'b1; end
        90: begin io_addr = 3'd5; io_rd = 1'b1; end
        default: ;
      endcase
    end
    check("fill_cycles_bad", bad, 0);
    check("fill_rdata_valid", vcnt, 0);
    @(negedge clk);
    check("fill_done", {30'h0, mem_we, busy}, 32'h0);
    rd_reg(3'd2, d, v);
    check("fill_ptr_lo", {23'h0, v, d}, 32'h155);
    rd_reg(3'd3, d, v);
    check("fill_ptr_hi", {23'h0, v, d}, 32'h100);
    bad = 0;
    for (int k = 0; k < 16384; k++) if (ram[k] !== 8'h00) bad++;
    check("fill_ram", bad, 0);

    // Reset in the middle of a fill
    @(negedge clk);
    io_addr = 3'd6; io_wdata = 8'h42; io_wr = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      io_wr = 1'b0;
      if (i == 100) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ctl", {mem_we, busy, port0_valid, port1_valid, io_rdata_valid, 27'h0}, 32'h0);
    check("abort_data", {port0, port1, io_rdata, mem_wdata}, 32'h0);
    check("abort_addr", {18'h0, mem_addr}, 32'h0);
    wcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we !== 1'b0) wcnt++;
    end
    check("abort_no_we", wcnt, 0);
    check("abort_ram", {16'h0, ram[100], ram[101]}, 32'h4200);
    rd_reg(3'd2, d, v);
    check("abort_ptr_lo", {23'h0, v, d}, 32'h100);
    rd_reg(3'd3, d, v);
    check("abort_ptr_hi", {23'h0, v, d}, 32'h100);

    // Simultaneous write and read strobes
    @(negedge clk);
    io_addr = 3'd4; io_wdata = 8'h77; io_wr = 1'b1; io_rd = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    check("wr_rd_we", {mem_we, io_rdata_valid, 8'h0, mem_addr, mem_wdata}, {2'b10, 8'h0, 14'h0, 8'h77});
    @(negedge clk);
    check("wr_rd_novalid", {31'h0, io_rdata_valid}, 32'h0);
    check("wr_rd_ram", {24'h0, ram[0]}, 32'h77);
    rd_reg(3'd7, d, v);
    check("status", {23'h0, v, d}, 32'h100);
    rd_reg(3'd6, d, v);
    check("unmapped_rd", {23'h0, v, d}, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
